// File: rtl/g711_pcm_tx.sv
// A-law codeword FIFO feeding one timeslot of a TDM PCM highway.
// The optional even-bit inversion is applied at load time, and an idle code is sent when no sample is queued.
module g711_pcm_tx #(
    parameter int DEPTH  = 4,
    parameter int SLOTS  = 32,
    parameter int SLOT   = 0,
    parameter int INVERT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               enc_in,
    input  logic                     enc_valid,
    output logic                     enc_ready,
    input  logic                     bit_en,
    output logic                     pcm_out,
    output logic                     pcm_oe,
    output logic                     fsync,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SW-1:0] SLOT_IDX  = SW'(SLOT);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
    localparam logic [7:0]    XOR_MASK  = (INVERT != 0) ? 8'h55 : 8'h00;
    localparam logic [7:0]    IDLE_CODE = (INVERT != 0) ? 8'hD5 : 8'h80;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_fill;
    logic          r_ready;
    logic [SW-1:0] r_slot;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_pcm;
    logic          r_oe;
    logic          r_fsync;
    logic          r_under;

    logic [SW-1:0] w_nslot;
    logic [2:0]    w_nbit;
    logic          w_active;
    logic          w_start;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_fill_nxt;
    logic [7:0]    w_load;

    // Next timeslot position, slot-start decode and FIFO bookkeeping
    always_comb begin
        w_nbit = r_bit + 3'd1;
        if (r_bit == 3'd7) begin
            if (r_slot == SLOT_LAST) begin
                w_nslot = '0;
            end else begin
                w_nslot = r_slot + SW'(1);
            end
        end else begin
            w_nslot = r_slot;
        end
        w_active = bit_en && (w_nslot == SLOT_IDX);
        w_start  = w_active && (w_nbit == 3'd0);
        w_push   = enc_valid && r_ready;
        w_pop    = w_start && (r_fill != '0);
        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + (AW + 1)'(1);
        end else if (w_pop && !w_push) begin
            w_fill_nxt = r_fill - (AW + 1)'(1);
        end else begin
            w_fill_nxt = r_fill;
        end
        // An empty FIFO at slot start sends the idle code even if a push lands this cycle
        if (r_fill != '0) begin
            w_load = r_mem[r_rd] ^ XOR_MASK;
        end else begin
            w_load = IDLE_CODE;
        end
    end

    // Codeword storage; stale entries are harmless because pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= enc_in;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_fill  <= '0;
            r_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_fill  <= w_fill_nxt;
            r_ready <= (w_fill_nxt < FULL);
        end
    end

    // Slot/bit counters, shift register and serial outputs, all advancing on bit_en
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot  <= SLOT_LAST;
            r_bit   <= 3'd7;
            r_shift <= 8'h00;
            r_pcm   <= 1'b0;
            r_oe    <= 1'b0;
            r_fsync <= 1'b0;
            r_under <= 1'b0;
        end else begin
            r_under <= w_start && (r_fill == '0);
            if (bit_en) begin
                r_slot  <= w_nslot;
                r_bit   <= w_nbit;
                r_fsync <= (w_nslot == '0) && (w_nbit == 3'd0);
                if (w_start) begin
                    r_shift <= w_load;
                    r_pcm   <= w_load[7];
                    r_oe    <= 1'b1;
                end else if (w_active) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_pcm   <= r_shift[6];
                    r_oe    <= 1'b1;
                end else begin
                    r_pcm   <= 1'b0;
                    r_oe    <= 1'b0;
                end
            end
        end
    end

    assign enc_ready = r_ready;
    assign fill      = r_fill;
    assign pcm_out   = r_pcm;
    assign pcm_oe    = r_oe;
    assign fsync     = r_fsync;
    assign underrun  = r_under;

endmodule

// File: tb/tb_g711_pcm_tx.sv
// Scoreboard bench: two instances (inverting and plain) share stimulus; a monitor
// reassembles each slot's byte and checks it against queued hand-computed values.
module tb_g711_pcm_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] enc_in;
    logic       enc_valid;
    logic       bit_en;
    logic       rdy0, rdy1, pcm0, pcm1, oe0, oe1, fs0, fs1, ur0, ur1;
    logic [2:0] fill0, fill1;

    g711_pcm_tx #(.DEPTH(4), .SLOTS(4), .SLOT(1), .INVERT(1)) dut_inv (
        .clk(clk), .reset(reset), .enc_in(enc_in), .enc_valid(enc_valid),
        .enc_ready(rdy0), .bit_en(bit_en), .pcm_out(pcm0), .pcm_oe(oe0),
        .fsync(fs0), .underrun(ur0), .fill(fill0));

    g711_pcm_tx #(.DEPTH(4), .SLOTS(4), .SLOT(1), .INVERT(0)) dut_raw (
        .clk(clk), .reset(reset), .enc_in(enc_in), .enc_valid(enc_valid),
        .enc_ready(rdy1), .bit_en(bit_en), .pcm_out(pcm1), .pcm_oe(oe1),
        .fsync(fs1), .underrun(ur1), .fill(fill1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] inv;
        logic [7:0] raw;
        logic       ur;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   bytes_seen = 0;
    int   stray_ur = 0;
    int   sp_slot, sp_bit;
    int   mn_slot = 3, mn_bit = 7;
    logic [7:0] acc0 = 8'h00, acc1 = 8'h00;
    logic ur_at_start0 = 1'b0, ur_at_start1 = 1'b0;
    logic rst_d = 1'b0, ben_d = 1'b0;
    logic accepted;
    int   n_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        rst_d <= reset;
        ben_d <= bit_en;
    end

    // Monitor: sample one half-cycle after each edge, track the frame position independently
    always @(negedge clk) begin
        exp_t e;
        if (rst_d) begin
            chk("rst_oe", {oe0, oe1}, 2'b00);
            chk("rst_pcm", {pcm0, pcm1}, 2'b00);
            chk("rst_fsync_ur", {fs0, fs1, ur0, ur1}, 4'b0000);
            chk("rst_fill", {fill0, fill1}, 6'd0);
            chk("rst_ready", {rdy0, rdy1}, 2'b11);
            mn_slot = 3;
            mn_bit  = 7;
            acc0 = 8'h00;
            acc1 = 8'h00;
        end else if (ben_d) begin
            mn_bit = (mn_bit + 1) % 8;
            if (mn_bit == 0) mn_slot = (mn_slot + 1) % 4;
            chk("fsync", {fs0, fs1}, (mn_slot == 0 && mn_bit == 0) ? 2'b11 : 2'b00);
            chk("pcm_oe", {oe0, oe1}, (mn_slot == 1) ? 2'b11 : 2'b00);
            if (mn_slot == 1) begin
                acc0 = {acc0[6:0], pcm0};
                acc1 = {acc1[6:0], pcm1};
                if (mn_bit == 0) begin
                    ur_at_start0 = ur0;
                    ur_at_start1 = ur1;
                end else if (ur0 || ur1) begin
                    stray_ur++;
                end
                if (mn_bit == 7) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {acc0, acc1}, 16'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte_inv", acc0, e.inv);
                        chk("byte_raw", acc1, e.raw);
                        chk("underrun", {ur_at_start0, ur_at_start1}, {e.ur, e.ur});
                    end
                end
            end else begin
                chk("pcm_idle", {pcm0, pcm1}, 2'b00);
                if (ur0 || ur1) stray_ur++;
            end
        end else if (ur0 || ur1) begin
            stray_ur++;
        end
    end

    // One clock of stimulus, launched at a falling edge
    task automatic cyc(input logic ben, input logic v, input logic [7:0] d, output logic acc);
        bit_en    = ben;
        enc_valid = v;
        enc_in    = d;
        acc       = v & rdy0;
        @(negedge clk);
        bit_en    = 1'b0;
        enc_valid = 1'b0;
    endtask

    task automatic bit_cycle(input logic v, input logic [7:0] d, output logic acc);
        cyc(1'b1, v, d, acc);
        sp_bit = (sp_bit + 1) % 8;
        if (sp_bit == 0) sp_slot = (sp_slot + 1) % 4;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) cyc(1'b0, 1'b0, 8'h00, a);
    endtask

    task automatic strobes(input int n);
        logic a;
        repeat (n) begin
            bit_cycle(1'b0, 8'h00, a);
            idle(3);
        end
    endtask

    task automatic to_slot_start;
        while (!(sp_slot == 0 && sp_bit == 7)) strobes(1);
    endtask

    task automatic push(input logic [7:0] d, output logic acc);
        cyc(1'b0, 1'b1, d, acc);
    endtask

    task automatic do_reset(input int n);
        logic a;
        reset = 1'b1;
        repeat (n) cyc(1'b0, 1'b0, 8'h00, a);
        reset = 1'b0;
        sp_slot = 3;
        sp_bit  = 7;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words [6];
        words[0] = 8'h01; words[1] = 8'h12; words[2] = 8'h23;
        words[3] = 8'h34; words[4] = 8'h45; words[5] = 8'h56;
        reset = 1'b1; bit_en = 1'b0; enc_valid = 1'b0; enc_in = 8'h00;
        @(negedge clk);
        do_reset(2);

        // Empty FIFO: idle code each frame with an underrun pulse
        exp_q.push_back('{inv: 8'hD5, raw: 8'h80, ur: 1'b1});
        exp_q.push_back('{inv: 8'hD5, raw: 8'h80, ur: 1'b1});
        strobes(64);

        // Two words queued ahead of the slot; fill drains 2 -> 1 -> 0
        push(8'h80, accepted);
        push(8'h2A, accepted);
        exp_q.push_back('{inv: 8'hD5, raw: 8'h80, ur: 1'b0});
        exp_q.push_back('{inv: 8'h7F, raw: 8'h2A, ur: 1'b0});
        idle(1);
        chk("t2_fill2", fill0, 3'd2);
        to_slot_start();
        strobes(1);
        chk("t2_fill1", fill0, 3'd1);
        strobes(23 + 32);
        chk("t2_fill0", fill0, 3'd0);

        // Six back-to-back pushes: only four fit
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            push(words[i], accepted);
            if (accepted) n_acc++;
        end
        chk("t3_accepted", n_acc, 4);
        chk("t3_fill_full", fill0, 3'd4);
        chk("t3_ready_low", {rdy0, rdy1}, 2'b00);
        exp_q.push_back('{inv: 8'h54, raw: 8'h01, ur: 1'b0});
        exp_q.push_back('{inv: 8'h47, raw: 8'h12, ur: 1'b0});
        exp_q.push_back('{inv: 8'h76, raw: 8'h23, ur: 1'b0});
        exp_q.push_back('{inv: 8'h61, raw: 8'h34, ur: 1'b0});
        exp_q.push_back('{inv: 8'h10, raw: 8'h45, ur: 1'b0});
        to_slot_start();
        bit_cycle(1'b0, 8'h00, accepted);
        chk("t3_fill3", fill0, 3'd3);
        chk("t3_ready_back", {rdy0, rdy1}, 2'b11);
        push(words[4], accepted);
        chk("t3_fifth_accepted", accepted, 1'b1);
        idle(2);
        strobes(23 + 4 * 32);
        chk("t3_drained", fill0, 3'd0);

        // 0xA5 then an empty frame
        push(8'hA5, accepted);
        exp_q.push_back('{inv: 8'hF0, raw: 8'hA5, ur: 1'b0});
        exp_q.push_back('{inv: 8'hD5, raw: 8'h80, ur: 1'b1});
        strobes(64);

        // Reset at bit 3 of the active slot with two words still queued
        push(8'h0F, accepted);
        push(8'hF0, accepted);
        push(8'h3C, accepted);
        to_slot_start();
        strobes(3);
        bit_cycle(1'b0, 8'h00, accepted);
        chk("t5_fill2", fill0, 3'd2);
        chk("t5_oe_mid", {oe0, oe1}, 2'b11);
        do_reset(1);
        exp_q.push_back('{inv: 8'hD5, raw: 8'h80, ur: 1'b1});
        strobes(32);

        // Push coinciding with slot start on an empty FIFO
        to_slot_start();
        bit_cycle(1'b1, 8'h11, accepted);
        chk("t6_accepted", accepted, 1'b1);
        exp_q.push_back('{inv: 8'hD5, raw: 8'h80, ur: 1'b1});
        exp_q.push_back('{inv: 8'h44, raw: 8'h11, ur: 1'b0});
        idle(3);
        chk("t6_fill1", {fill0, fill1}, {3'd1, 3'd1});
        strobes(23 + 32);
        chk("t6_fill0", fill0, 3'd0);

        idle(4);
        chk("bytes_seen", bytes_seen, 14);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("stray_underrun", stray_ur, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
